// File: rtl/ysyx_23060042_mem_pkg.sv
// Shared definitions for the data-memory responder.
//   state_e            : responder FSM states
//   LAT_W              : width of the latency down-counter
//   ADDR_BASE_DEFAULT  : default byte address of word 0
package ysyx_23060042_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned LAT_W             = 4;
  localparam logic [31:0] ADDR_BASE_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/ysyx_23060042_sram_array.sv
// Word-addressed storage for the data-memory responder. No reset on contents.
//   clk    : clock
//   wen    : write enable, byte lanes selected by wmask
//   ren    : read enable, rdata updated on the same edge
//   idx    : word index
//   wdata  : write data
//   wmask  : byte strobes, bit i writes lane i
//   rdata  : registered read data, holds until the next read
module ysyx_23060042_sram_array #(
  parameter int unsigned DEPTH_WORDS = 4096
) (
  input  logic                           clk,
  input  logic                           wen,
  input  logic                           ren,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [31:0]                    wdata,
  input  logic [3:0]                     wmask,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (wen) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wmask[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ren) rdata <= mem[idx];
  end

endmodule

// File: rtl/ysyx_23060042_dmem_responder.sv
// Memory-side responder for the LSU data port: one request per transaction over
// a valid/ready handshake, a fixed latency, then a response over a second
// valid/ready handshake.
//   clk, rst                : clock, synchronous active-high reset
//   req_valid/req_ready     : request handshake (ready only in IDLE)
//   req_wen/addr/wdata/wmask: store flag, byte address, store data, byte strobes
//   rsp_valid/rsp_ready     : response handshake
//   rsp_rdata               : load word, zero for stores and errors
//   rsp_err                 : address outside the backing array
module ysyx_23060042_dmem_responder
  import ysyx_23060042_mem_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = ADDR_BASE_DEFAULT,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned      IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [32:0]      SPAN     = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [LAT_W-1:0] CNT_INIT = (LATENCY > 1) ? LAT_W'(LATENCY - 2) : '0;

  state_e           state, state_nxt;
  logic [LAT_W-1:0] cnt, cnt_nxt;

  logic        l_wen;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic [3:0]  l_wmask;

  logic        accept;
  logic        enter_resp;
  logic        eff_wen;
  logic [31:0] eff_addr;
  logic [31:0] eff_wdata;
  logic [3:0]  eff_wmask;
  logic [31:0] offset;
  logic        in_range;
  logic        mem_wen;
  logic        mem_ren;
  logic [31:0] mem_rdata;
  logic        rsp_ld;

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // With LATENCY==1 the RESP-entry edge is the accept edge itself, so the
  // array must see the live request rather than the not-yet-latched copy.
  assign enter_resp = (accept && (LATENCY == 1)) || ((state == WAIT) && (cnt == '0));
  assign eff_wen    = (state == IDLE) ? req_wen   : l_wen;
  assign eff_addr   = (state == IDLE) ? req_addr  : l_addr;
  assign eff_wdata  = (state == IDLE) ? req_wdata : l_wdata;
  assign eff_wmask  = (state == IDLE) ? req_wmask : l_wmask;

  // Unsigned wrap makes addresses below the base fail the same compare.
  assign offset   = eff_addr - ADDR_BASE;
  assign in_range = {1'b0, offset} < SPAN;

  // rst gating keeps a store caught by reset in WAIT from ever committing.
  assign mem_wen = enter_resp && !rst && in_range && eff_wen;
  assign mem_ren = enter_resp && !rst && in_range && !eff_wen;

  ysyx_23060042_sram_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .wen   (mem_wen),
    .ren   (mem_ren),
    .idx   (offset[IDX_W+1:2]),
    .wdata (eff_wdata),
    .wmask (eff_wmask),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) state_nxt = RESP;
        else           cnt_nxt   = cnt - LAT_W'(1);
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      l_wen   <= req_wen;
      l_addr  <= req_addr;
      l_wdata <= req_wdata;
      l_wmask <= req_wmask;
    end
  end

  // The array's read register holds its value until the next read, so only a
  // load flag is kept here to zero the data for stores and errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_err <= 1'b0;
      rsp_ld  <= 1'b0;
    end else if (enter_resp) begin
      rsp_err <= !in_range;
      rsp_ld  <= in_range && !eff_wen;
    end
  end

  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rsp_ld ? mem_rdata : '0;

endmodule

// File: tb/tb_ysyx_23060042_dmem_responder.sv
module tb_ysyx_23060042_dmem_responder;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        req_valid;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        rsp_ready;

  logic        v0, v1;
  logic        rdy0, rdy1, rv0, rv1, err0, err1;
  logic [31:0] rd0, rd1;
  logic        req_ready_m, rsp_valid_m, rsp_err_m;
  logic [31:0] rsp_rdata_m;

  int n_checks = 0;
  int n_fail   = 0;

  assign v0 = req_valid && !sel;
  assign v1 = req_valid && sel;
  assign req_ready_m = sel ? rdy1 : rdy0;
  assign rsp_valid_m = sel ? rv1  : rv0;
  assign rsp_err_m   = sel ? err1 : err0;
  assign rsp_rdata_m = sel ? rd1  : rd0;

  ysyx_23060042_dmem_responder #(
    .ADDR_BASE   (32'h8000_0000),
    .DEPTH_WORDS (4096),
    .LATENCY     (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (v0),
    .req_ready (rdy0),
    .req_wen   (req_wen),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wmask (req_wmask),
    .rsp_valid (rv0),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rd0),
    .rsp_err   (err0)
  );

  ysyx_23060042_dmem_responder #(
    .ADDR_BASE   (32'h8000_0000),
    .DEPTH_WORDS (4096),
    .LATENCY     (1)
  ) dut1 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (v1),
    .req_ready (rdy1),
    .req_wen   (req_wen),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wmask (req_wmask),
    .rsp_valid (rv1),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rd1),
    .rsp_err   (err1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Full transaction on the selected instance, sampling on negedges.
  task automatic txn(input string name, input logic wen, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] wmask,
                     input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    int exp_lat;
    exp_lat = sel ? 1 : 2;
    @(negedge clk);
    chk({name, "_req_ready"}, 32'(req_ready_m), 32'd1);
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    req_wmask = wmask;
    @(posedge clk);
    #1;
    // Scramble the request bus after accept; the responder must ignore it.
    req_valid = 1'b0;
    req_wen   = ~wen;
    req_addr  = '1;
    req_wdata = '1;
    req_wmask = '1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid_m && n < 20);
    chk({name, "_rsp_valid"}, 32'(rsp_valid_m), 32'd1);
    chk({name, "_latency"}, 32'(n), 32'(exp_lat));
    chk({name, "_rdata"}, rsp_rdata_m, exp_rdata);
    chk({name, "_err"}, 32'(rsp_err_m), 32'(exp_err));
    chk({name, "_busy"}, 32'(req_ready_m), 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk({name, "_valid_drop"}, 32'(rsp_valid_m), 32'd0);
    chk({name, "_ready_back"}, 32'(req_ready_m), 32'd1);
  endtask

  vec_t vecs[14];

  initial begin
    int n;
    logic [31:0] held;

    vecs[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF,    32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h8000_0010, 32'h0000_0000, 4'h0,    32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h8000_0010, 32'h1122_3344, 4'b0101, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b0, 32'h8000_0010, 32'h0000_0000, 4'h0,    32'hDE22_BE44, 1'b0};
    vecs[4]  = '{1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'b0000, 32'h0000_0000, 1'b0};
    vecs[5]  = '{1'b0, 32'h8000_0013, 32'h0000_0000, 4'h0,    32'hDE22_BE44, 1'b0};
    vecs[6]  = '{1'b1, 32'h8000_3FFC, 32'h1234_5678, 4'hF,    32'h0000_0000, 1'b0};
    vecs[7]  = '{1'b1, 32'h8000_0000, 32'h0BAD_F00D, 4'hF,    32'h0000_0000, 1'b0};
    vecs[8]  = '{1'b0, 32'h7FFF_FFFC, 32'h0000_0000, 4'h0,    32'h0000_0000, 1'b1};
    vecs[9]  = '{1'b0, 32'h8000_4000, 32'h0000_0000, 4'h0,    32'h0000_0000, 1'b1};
    vecs[10] = '{1'b1, 32'h8000_4000, 32'hAAAA_AAAA, 4'hF,    32'h0000_0000, 1'b1};
    vecs[11] = '{1'b1, 32'h7FFF_FFFC, 32'h5555_5555, 4'hF,    32'h0000_0000, 1'b1};
    vecs[12] = '{1'b0, 32'h8000_3FFC, 32'h0000_0000, 4'h0,    32'h1234_5678, 1'b0};
    vecs[13] = '{1'b0, 32'h8000_0000, 32'h0000_0000, 4'h0,    32'h0BAD_F00D, 1'b0};

    rst = 1'b1; sel = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;

    // Reset and idle
    repeat (3) @(negedge clk);
    chk("rst_ready0", 32'(rdy0), 32'd0);
    chk("rst_ready1", 32'(rdy1), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_valid", 32'({rv0, rv1}), 32'd0);
      chk("idle_ready", 32'({rdy0, rdy1}), 32'd3);
      chk("idle_err",   32'({err0, err1}), 32'd0);
      chk("idle_rdata", rd0 | rd1, 32'd0);
    end

    // Directed vectors
    for (int i = 0; i < 14; i++) begin
      txn($sformatf("vec%0d", i), vecs[i].wen, vecs[i].addr, vecs[i].wdata,
          vecs[i].wmask, vecs[i].exp_rdata, vecs[i].exp_err);
    end

    // Backpressure with a second request waiting
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0010;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rv0 && n < 20);
    chk("bp_valid", 32'(rv0), 32'd1);
    chk("bp_rdata", rd0, 32'hDE22_BE44);
    held = rd0;
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0020;
    req_wdata = 32'h0000_0077; req_wmask = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(rv0), 32'd1);
      chk("bp_hold_rdata", rd0, held);
      chk("bp_hold_ready", 32'(rdy0), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_after_valid", 32'(rv0), 32'd0);
    chk("bp_after_ready", 32'(rdy0), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("bp_second_accepted", 32'(rdy0), 32'd0);
    n = 1;
    while (!rv0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_second_latency", 32'(n), 32'd2);
    chk("bp_second_err", 32'(err0), 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    txn("bp_readback", 1'b0, 32'h8000_0020, 32'h0, 4'h0, 32'h0000_0077, 1'b0);

    // Reset while a store waits
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0010;
    req_wdata = 32'hCAFE_F00D; req_wmask = 4'hF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("mid_in_wait", 32'(rv0), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid_no_rsp", 32'(rv0), 32'd0);
    end
    txn("mid_readback", 1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0);

    // Single-cycle latency instance
    sel = 1'b1;
    txn("lat1_store", 1'b1, 32'h8000_0100, 32'hA5A5_A5A5, 4'hF, 32'h0, 1'b0);
    txn("lat1_load",  1'b0, 32'h8000_0100, 32'h0, 4'h0, 32'hA5A5_A5A5, 1'b0);
    txn("lat1_oor",   1'b0, 32'h8000_4000, 32'h0, 4'h0, 32'h0, 1'b1);
    sel = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
